// File: rtl/cmp_nb_seq_pkg.sv
// Shared types for the iterative comparator: FSM state encoding, result
// codes and the mapping from a result code to the three output flags.
package cmp_nb_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RES_EQ = 2'd0,
    RES_GT = 2'd1,
    RES_LT = 2'd2
  } res_t;

  // Flag vector ordering is {eq, gt, lt}; exactly one bit set for a valid code.
  function automatic logic [2:0] res_flags(input res_t r);
    case (r)
      RES_EQ:  return 3'b100;
      RES_GT:  return 3'b010;
      RES_LT:  return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/cmp_nb_seq_chunk.sv
// Combinational compare of one CHUNK-bit slice; the caller has already
// biased the sign bit in signed mode, so an unsigned compare is sufficient.
module cmp_chunk_comb #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  assign eq = (a == b);
  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/cmp_nb_seq.sv
// Iterative magnitude comparator: walks the operands CHUNK bits per cycle,
// MSB chunk first, and stops on the first differing chunk. Signed compares
// flip the operand sign bits so the same unsigned chunk compare applies.
module cmp_nb_seq
  import cmp_nb_seq_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CHUNK     = 4,
  parameter int SIGNED_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_is_equal,
  output logic             a_is_greater,
  output logic             a_is_smaller
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CHUNK-1:0] ONE      = 1;
  localparam logic [CHUNK-1:0] MSB_MASK = ONE << (CHUNK - 1);

  // Reject illegal geometries at elaboration time.
  generate
    if ((CHUNK < 1) || (WIDTH < CHUNK) || ((WIDTH % CHUNK) != 0)) begin : g_bad_geometry
      $error("cmp_nb_seq: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             sgn_reg;
  logic [IW-1:0]    idx_reg, idx_next;
  logic [2:0]       flags_reg;
  logic             capture, flag_load;
  res_t             res;

  logic [CHUNK-1:0] a_chunk [NCHUNK];
  logic [CHUNK-1:0] b_chunk [NCHUNK];
  logic [CHUNK-1:0] a_sel, b_sel;
  logic             c_eq, c_gt, c_lt;

  // Slice the captured operands; only the top chunk carries the sign bit.
  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
      if (gi == NCHUNK - 1) begin : g_top
        assign a_chunk[gi] = a_reg[gi*CHUNK +: CHUNK] ^ (sgn_reg ? MSB_MASK : '0);
        assign b_chunk[gi] = b_reg[gi*CHUNK +: CHUNK] ^ (sgn_reg ? MSB_MASK : '0);
      end else begin : g_low
        assign a_chunk[gi] = a_reg[gi*CHUNK +: CHUNK];
        assign b_chunk[gi] = b_reg[gi*CHUNK +: CHUNK];
      end
    end
  endgenerate

  assign a_sel = a_chunk[idx_reg];
  assign b_sel = b_chunk[idx_reg];

  cmp_chunk_comb #(.CHUNK(CHUNK)) u_chunk (
    .a  (a_sel),
    .b  (b_sel),
    .eq (c_eq),
    .gt (c_gt),
    .lt (c_lt)
  );

  // Next-state, chunk index and flag-load decisions.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    capture    = 1'b0;
    flag_load  = 1'b0;
    res        = RES_EQ;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          capture    = 1'b1;
          idx_next   = IW'(NCHUNK - 1);
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!c_eq) begin
          flag_load  = 1'b1;
          res        = c_gt ? RES_GT : RES_LT;
          state_next = ST_FIN;
        end else if (idx_reg == '0) begin
          flag_load  = 1'b1;
          res        = RES_EQ;
          state_next = ST_FIN;
        end else begin
          idx_next = idx_reg - 1'b1;
        end
      end
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State and chunk index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  // Operand capture; later changes on a/b/is_signed are invisible to a compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sgn_reg <= 1'b0;
    end else if (capture) begin
      a_reg   <= a;
      b_reg   <= b;
      sgn_reg <= is_signed & (SIGNED_EN != 0);
    end
  end

  // Result flags change only on the edge entering FIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_reg <= 3'b000;
    end else if (flag_load) begin
      flags_reg <= res_flags(res);
    end
  end

  assign busy         = (state_reg != ST_IDLE);
  assign done         = (state_reg == ST_FIN);
  assign a_is_equal   = flags_reg[2];
  assign a_is_greater = flags_reg[1];
  assign a_is_smaller = flags_reg[0];

endmodule
